// File: rtl/usb_sie_rx.sv
// USB SIE receive decoder: validates the PID, parses token fields, checks CRC5/CRC16 and
// delivers data payloads with the trailing CRC16 stripped, one verdict per packet.
module usb_sie_rx #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_error,
    output logic        pkt_start,
    output logic [3:0]  pkt_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] sof_frame,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pkt_done,
    output logic        pkt_ok
);
    typedef enum logic [2:0] {IDLE_S, PID_S, TOKEN_S, DATA_S, HSK_S, ERR_S, DONE_S} state_e;
    typedef enum logic [1:0] {C_BAD, C_TOK, C_DAT, C_HSK} cls_e;

    localparam logic [10:0] DATA_MAX = 11'(MAX_PAYLOAD + 2);
    localparam logic [3:0]  PID_SOF  = 4'b0101;

    function automatic cls_e pid_class(input logic [3:0] p);
        case (p)
            4'b0001, 4'b1001, 4'b1101, 4'b0101, 4'b0100: return C_TOK;
            4'b0011, 4'b1011, 4'b0111, 4'b1111:          return C_DAT;
            4'b0010, 4'b1010, 4'b1110, 4'b0110:          return C_HSK;
            default:                                     return C_BAD;
        endcase
    endfunction

    // Serial CRCs, bits consumed LSB-first as they came off the wire.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? 5'h05 : 5'h00);
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d;
    logic [10:0] cnt_q, cnt_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic        err_q, err_d;
    logic [7:0]  b0_q, b0_d, h0_q, h0_d, h1_q, h1_d;
    logic [2:0]  b1_q, b1_d;
    logic        start_q, start_d, plv_q, plv_d, done_q, ok_q;
    logic [3:0]  pid_q, pid_d, endp_q;
    logic [7:0]  pld_q, pld_d;
    logic [6:0]  addr_q;
    logic [10:0] frame_q;
    logic        pid_ok_w, byte_in, fin, ok_d;

    assign pid_ok_w = (rx_data[7:4] == ~rx_data[3:0]);

    always_comb begin
        state_d = state_q;  cls_d = cls_q;    cnt_d = cnt_q;
        crc5_d  = crc5_q;   crc16_d = crc16_q; err_d = err_q;
        b0_d    = b0_q;     b1_d = b1_q;      h0_d = h0_q;  h1_d = h1_q;
        start_d = 1'b0;     pid_d = pid_q;    pld_d = pld_q; plv_d = 1'b0;
        byte_in = 1'b0;
        case (state_q)
            IDLE_S: begin
                cls_d = C_BAD;  cnt_d = '0;  crc5_d = 5'h1F;  crc16_d = 16'hFFFF;  err_d = 1'b0;
                if (rx_active) begin
                    state_d = PID_S;
                    err_d   = rx_error;
                end
            end
            PID_S: begin
                if (rx_error) err_d = 1'b1;
                if (rx_valid) begin
                    cls_d = pid_ok_w ? pid_class(rx_data[3:0]) : C_BAD;
                    if (cls_d == C_BAD) err_d = 1'b1;
                    else begin
                        start_d = 1'b1;
                        pid_d   = rx_data[3:0];
                    end
                    case (cls_d)
                        C_TOK:   state_d = TOKEN_S;
                        C_DAT:   state_d = DATA_S;
                        C_HSK:   state_d = HSK_S;
                        default: state_d = ERR_S;
                    endcase
                end
                if (!rx_active) state_d = DONE_S;
            end
            TOKEN_S, DATA_S, HSK_S, ERR_S: begin
                if (rx_error) err_d = 1'b1;
                byte_in = rx_valid;
                if (!rx_active) state_d = DONE_S;
            end
            default: state_d = IDLE_S;
        endcase

        if (byte_in) begin
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
            crc5_d  = crc5_byte(crc5_q, rx_data);
            crc16_d = crc16_byte(crc16_q, rx_data);
            if (cnt_q == 11'd0) b0_d = rx_data;
            if (cnt_q == 11'd1) b1_d = rx_data[2:0];
            h0_d = h1_q;
            h1_d = rx_data;
            // The two newest bytes may be the CRC, so only the byte two behind is released.
            if (state_q == DATA_S && cnt_q >= 11'd2 && cnt_q < DATA_MAX) begin
                plv_d = 1'b1;
                pld_d = h0_q;
            end
        end
    end

    // Verdict is taken from next-state values so a byte arriving with rx_active's fall counts.
    assign fin = (state_d == DONE_S);
    always_comb begin
        case (cls_d)
            C_TOK:   ok_d = (cnt_d == 11'd2) && (crc5_d == 5'b01100);
            C_DAT:   ok_d = (cnt_d >= 11'd2) && (cnt_d <= DATA_MAX) && (crc16_d == 16'h800D);
            C_HSK:   ok_d = (cnt_d == 11'd0);
            default: ok_d = 1'b0;
        endcase
        ok_d = ok_d && !err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_S;  cls_q <= C_BAD;  cnt_q <= '0;
            crc5_q  <= 5'h1F;   crc16_q <= 16'hFFFF;  err_q <= 1'b0;
            b0_q <= '0;  b1_q <= '0;  h0_q <= '0;  h1_q <= '0;
            start_q <= 1'b0;  pid_q <= '0;  pld_q <= '0;  plv_q <= 1'b0;
            done_q  <= 1'b0;  ok_q <= 1'b0;
            addr_q  <= '0;    endp_q <= '0;  frame_q <= '0;
        end else begin
            state_q <= state_d;  cls_q <= cls_d;  cnt_q <= cnt_d;
            crc5_q  <= crc5_d;   crc16_q <= crc16_d;  err_q <= err_d;
            b0_q <= b0_d;  b1_q <= b1_d;  h0_q <= h0_d;  h1_q <= h1_d;
            start_q <= start_d;  pid_q <= pid_d;  pld_q <= pld_d;  plv_q <= plv_d;
            done_q  <= fin;
            ok_q    <= fin && ok_d;
            if (fin && ok_d && cls_d == C_TOK) begin
                if (pid_q == PID_SOF) frame_q <= {b1_d, b0_d};
                else begin
                    addr_q <= b0_d[6:0];
                    endp_q <= {b1_d, b0_d[7]};
                end
            end
        end
    end

    assign pkt_start = start_q;
    assign pkt_pid   = pid_q;
    assign tok_addr  = addr_q;
    assign tok_endp  = endp_q;
    assign sof_frame = frame_q;
    assign pl_data   = pld_q;
    assign pl_valid  = plv_q;
    assign pkt_done  = done_q;
    assign pkt_ok    = ok_q;
endmodule
